// File: rtl/aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_round_ctrl
//
// Round-sequencing controller for the pipelined AES datapath. Handles AES-128,
// AES-192 and AES-256 in encrypt and decrypt direction.
//
// A start request from the command interface triggers two phases:
//   1. Key expansion: key_gene_en is pulsed once per round key while
//      Round_Count walks 1..Nr.
//   2. Round phase: round_en is high while Round_Count walks 0..Nr (encrypt)
//      or Nr..0 (decrypt). first_round and last_round flag the two ends.
// A single-cycle done pulse closes the operation. Every output is registered.
//
// Parameters:
//   ROUND_W     width of Round_Count; must be at least 4 so that 14 fits.
//   SUPPORT_192 when 0, key_len=01 is rejected with an err pulse.
//   SUPPORT_256 when 0, key_len=10 is rejected with an err pulse.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   start        operation request, only looked at while idle
//   key_len      00=AES-128, 01=AES-192, 10=AES-256, 11=reserved
//   decrypt      0=encrypt, 1=decrypt (latched together with key_len)
//   stall        freezes state and counter; enables drop low meanwhile
//   abort        cancels a running key-expansion or round phase
//   busy         high while an operation is in flight (incl. the done cycle)
//   key_gene_en  key-expansion step enable
//   round_en     round datapath enable
//   Round_Count  key index during expansion, round index during rounds
//   first_round  Round_Count holds the first round of the round phase
//   last_round   Round_Count holds the final round (no MixColumns)
//   done         one-cycle completion pulse
//   err          one-cycle pulse when a start request is rejected
// -----------------------------------------------------------------------------
module aes_round_ctrl #(
  parameter int ROUND_W     = 4,
  parameter bit SUPPORT_192 = 1'b1,
  parameter bit SUPPORT_256 = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         key_len,
  input  logic               decrypt,
  input  logic               stall,
  input  logic               abort,
  output logic               busy,
  output logic               key_gene_en,
  output logic               round_en,
  output logic [ROUND_W-1:0] Round_Count,
  output logic               first_round,
  output logic               last_round,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_KEY_EXP = 2'd1,
    ST_ROUNDS  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [ROUND_W-1:0] NR_128 = ROUND_W'(10);
  localparam logic [ROUND_W-1:0] NR_192 = ROUND_W'(12);
  localparam logic [ROUND_W-1:0] NR_256 = ROUND_W'(14);
  localparam logic [ROUND_W-1:0] ONE    = ROUND_W'(1);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t             state_reg,       state_next;
  logic [ROUND_W-1:0] cnt_reg,         cnt_next;
  logic [1:0]         key_len_reg,     key_len_next;
  logic               dec_reg,         dec_next;
  logic               busy_reg,        busy_next;
  logic               key_gene_en_reg, key_gene_en_next;
  logic               round_en_reg,    round_en_next;
  logic               first_reg,       first_next;
  logic               last_reg,        last_next;
  logic               done_reg,        done_next;
  logic               err_reg,         err_next;

  // ---------------------------------------------------------------------------
  // Key-length support mask, one bit per key_len code. The reserved code 11
  // is never supported.
  // ---------------------------------------------------------------------------
  logic [3:0] len_ok;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_len_ok
      if (gi == 0) begin : g_128
        assign len_ok[gi] = 1'b1;
      end else if (gi == 1) begin : g_192
        assign len_ok[gi] = SUPPORT_192;
      end else if (gi == 2) begin : g_256
        assign len_ok[gi] = SUPPORT_256;
      end else begin : g_rsvd
        assign len_ok[gi] = 1'b0;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round count of the latched key size. Only supported codes are ever
  // latched, so the default arm is unreachable in practice.
  // ---------------------------------------------------------------------------
  logic [ROUND_W-1:0] nr;

  always_comb begin
    nr = NR_128;
    case (key_len_reg)
      2'b01:   nr = NR_192;
      2'b10:   nr = NR_256;
      default: nr = NR_128;
    endcase
  end

  // Round-phase direction: encrypt climbs 0..Nr, decrypt descends Nr..0.
  logic [ROUND_W-1:0] round_first;
  logic [ROUND_W-1:0] round_final;
  logic [ROUND_W-1:0] round_step;
  logic               round_term;

  assign round_first = dec_reg ? nr : '0;
  assign round_final = dec_reg ? '0 : nr;
  assign round_step  = dec_reg ? (cnt_reg - ONE) : (cnt_reg + ONE);
  // The terminal compare stops the counter before it could ever wrap.
  assign round_term  = (cnt_reg == round_final);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      key_len_reg     <= 2'b00;
      dec_reg         <= 1'b0;
      busy_reg        <= 1'b0;
      key_gene_en_reg <= 1'b0;
      round_en_reg    <= 1'b0;
      first_reg       <= 1'b0;
      last_reg        <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      key_len_reg     <= key_len_next;
      dec_reg         <= dec_next;
      busy_reg        <= busy_next;
      key_gene_en_reg <= key_gene_en_next;
      round_en_reg    <= round_en_next;
      first_reg       <= first_next;
      last_reg        <= last_next;
      done_reg        <= done_next;
      err_reg         <= err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic. Every *_next output value describes the
  // cycle that follows the current clock edge, which is what makes the outputs
  // registered rather than decoded from state.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    key_len_next     = key_len_reg;
    dec_next         = dec_reg;
    busy_next        = 1'b0;
    key_gene_en_next = 1'b0;
    round_en_next    = 1'b0;
    first_next       = 1'b0;
    last_next        = 1'b0;
    done_next        = 1'b0;
    err_next         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        // abort alongside start cancels the request outright (no err either).
        if (start && !abort) begin
          if (len_ok[key_len]) begin
            state_next       = ST_KEY_EXP;
            key_len_next     = key_len;
            dec_next         = decrypt;
            cnt_next         = ONE;
            busy_next        = 1'b1;
            key_gene_en_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      ST_KEY_EXP: begin
        busy_next = 1'b1;
        if (abort) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          busy_next  = 1'b0;
        end else if (stall) begin
          // Hold the key index; key_gene_en stays low for this cycle.
        end else if (cnt_reg == nr) begin
          state_next    = ST_ROUNDS;
          cnt_next      = round_first;
          round_en_next = 1'b1;
          first_next    = 1'b1;
        end else begin
          cnt_next         = cnt_reg + ONE;
          key_gene_en_next = 1'b1;
        end
      end

      ST_ROUNDS: begin
        busy_next = 1'b1;
        if (abort) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          busy_next  = 1'b0;
        end else if (stall) begin
          // Round index and its flags freeze; round_en drops for the cycle.
          first_next = first_reg;
          last_next  = last_reg;
        end else if (round_term) begin
          // Round_Count keeps the last round index through the done cycle.
          state_next = ST_DONE;
          done_next  = 1'b1;
        end else begin
          cnt_next      = round_step;
          round_en_next = 1'b1;
          last_next     = (round_step == round_final);
        end
      end

      ST_DONE: begin
        // Single cycle regardless of stall or abort.
        state_next = ST_IDLE;
        cnt_next   = '0;
      end

      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign busy        = busy_reg;
  assign key_gene_en = key_gene_en_reg;
  assign round_en    = round_en_reg;
  assign Round_Count = cnt_reg;
  assign first_round = first_reg;
  assign last_round  = last_reg;
  assign done        = done_reg;
  assign err         = err_reg;

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Parametrised round-sequencing controller for the pipelined AES datapath, supporting AES-128, AES-192 and AES-256 in both encrypt and decrypt direction. On a start request it first runs a key-expansion phase, driving key_gene_en once per round key. It then runs the round phase, stepping Round_Count up for encrypt or down for decrypt, and signals completion with a one-cycle done pulse. It sits between the top-level command interface and the key-expansion and round datapaths.

Parameters:
ROUND_W, 4, width of Round_Count; must be at least 4.
SUPPORT_192, 1, if 0 then key_len=01 is rejected as an error.
SUPPORT_256, 1, if 0 then key_len=10 is rejected as an error.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  request pulse; sampled only in IDLE.
key_len  in  2  00=128 (Nr=10), 01=192 (Nr=12), 10=256 (Nr=14), 11=reserved; latched on start.
decrypt  in  1  0=encrypt, 1=decrypt; latched on start.
stall  in  1  freezes state and counters while high.
abort  in  1  cancels the operation in progress.
busy  out  1  high in KEY_EXP, ROUNDS and DONE.
key_gene_en  out  1  key-expansion step enable.
round_en  out  1  round datapath enable.
Round_Count  out  ROUND_W  key index (KEY_EXP) or round index (ROUNDS).
first_round  out  1  high while Round_Count is the first round of the round phase.
last_round  out  1  high while Round_Count is the final round (no MixColumns).
done  out  1  one-cycle completion pulse.
err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- All outputs are registered. Asynchronous reset (rst=0) forces: state=IDLE, all outputs 0, latched key_len and decrypt = 0. Reset applies immediately in any state; no done is produced.
- States:
  - IDLE -> KEY_EXP on start with a supported key_len.
  - KEY_EXP -> ROUNDS when key count = Nr and stall=0.
  - ROUNDS -> DONE after the final round index and stall=0.
  - DONE -> IDLE unconditionally.
- Start with an unsupported key_len (11, or a size disabled by parameter): stay in IDLE, err=1 for one cycle.
- start outside IDLE is ignored; there is no queuing.
- KEY_EXP:
  - key_gene_en=1.
  - Round_Count runs 1..Nr, one value per unstalled cycle; Nr cycles total.
  - round_en=0.
- ROUNDS:
  - round_en=1.
  - Encrypt: Round_Count runs 0..Nr.
  - Decrypt: Round_Count runs Nr..0.
  - Nr+1 cycles total.
  - first_round=1 on the first value (0 for encrypt, Nr for decrypt).
  - last_round=1 on the final value (Nr for encrypt, 0 for decrypt).
- DONE:
  - done=1 for exactly one cycle; busy=1.
  - Round_Count holds its last value; then returns to 0 in IDLE.
- Latency: start accepted in cycle T.
  - KEY_EXP occupies T+1 .. T+Nr.
  - ROUNDS occupies T+Nr+1 .. T+2Nr+1.
  - done=1 at T+2Nr+2 (T+22 / T+26 / T+30), plus one cycle per stalled cycle.
- stall=1:
  - State, counter, first_round and last_round hold.
  - key_gene_en=0 and round_en=0 in the same registered cycle.
  - Stall in IDLE or DONE has no effect; DONE is never extended.
- abort=1 in KEY_EXP or ROUNDS:
  - Next cycle: IDLE, all outputs 0, no done.
  - abort has priority over stall.
  - abort in IDLE or DONE has no effect.
- abort and start together in IDLE: start is ignored.
- Counter arithmetic: ROUND_W-bit unsigned. Terminal compares are against the latched Nr; the counter never wraps.
- key_len and decrypt are ignored after latching; changes mid-operation have no effect.

Test Plan:
- Reset, then start with key_len=00, decrypt=0 at T -> key_gene_en high T+1..T+10 with Round_Count 1..10; round_en high T+11..T+21 with Round_Count 0..10; last_round at T+21; done pulse at T+22; busy low at T+23.
- key_len=10, decrypt=1 -> 14 key cycles; Round_Count 14 down to 0; first_round with count 14; last_round with count 0; done at T+30.
- key_len=01 with 3 stall cycles during ROUNDS -> done at T+29 (T+26 plus 3 stall cycles); Round_Count frozen and enables low during the stalls.
- key_len=11 -> err pulses for 1 cycle, busy stays 0; repeat with SUPPORT_256=0 and key_len=10 -> same response.
- abort at round 5 of AES-128 -> IDLE next cycle, no done; a new start is accepted normally afterwards. start asserted while busy -> ignored.
- rst asserted in KEY_EXP -> all outputs 0 immediately (asynchronous); after release, stays in IDLE until the next start.
